muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit for the execute stage, beside the ALU.
//  Consumes the same rs/rt operand buses as the ALU.
//  Implements MULT/MULTU/DIV/DIVU into the architectural HI/LO registers, plus MTHI/MTLO.
//  The execute stage stalls on busy and reads HI/LO (MFHI/MFLO) directly from the hi/lo outputs.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  reset_n   in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE
//  op        in   3      0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved (ignored)
//  a         in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
//  b         in   WIDTH  rt operand (multiplier / divisor)
//  cancel    in   1      pipeline flush; aborts an operation in flight
//  hi        out  WIDTH  HI register (product[63:32] / remainder)
//  lo        out  WIDTH  LO register (product[31:0] / quotient)
//  busy      out  1      operation in flight; HI/LO not yet valid
//  done      out  1      one-cycle pulse: HI/LO just updated by a mul/div
//  div_zero  out  1      sticky; set on divide by zero, cleared by next accepted mul/div
// BEHAVIOUR
//  Reset (reset_n low, any time, including mid-operation):
//   - state IDLE; hi = lo = 0; busy = done = div_zero = 0; counter = 0.
//  FSM states: IDLE, SETUP, ITER, FIX.
//   - IDLE -> SETUP on start & !cancel & op in 0..3.
//     Accept edge E0 latches a, b, op; busy = 1 from E0.
//   - SETUP (1 cycle): take magnitudes for signed ops (op 1/3); record result signs; counter = 0.
//   - ITER (WIDTH cycles): one radix-2 step per cycle.
//     Multiply: shift-add into a 2*WIDTH accumulator.
//     Divide: restoring shift-subtract.
//   - FIX (1 cycle): apply signs, write hi/lo.
//     On leaving FIX (edge E34 for WIDTH=32): busy = 0, done = 1 for exactly one cycle, return to IDLE.
//  Latency: hi/lo valid and done high in the cycle after E34; busy high from E0 through E34.
//  Signed rules:
//   - product sign = sign(a) ^ sign(b).
//   - quotient truncates toward zero; remainder takes the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0 (no trap, no flag).
//  Divide by zero (b == 0, op 2/3): detected in SETUP.
//   - At exit edge E1: hi = a, lo = all ones, div_zero = 1, done = 1; state -> IDLE.
//  MTHI/MTLO (op 4/5) with start in IDLE:
//   - hi (resp. lo) = a at that edge; no busy, no done; div_zero unchanged.
//  start while busy: ignored; no queueing. Reserved ops: ignored.
//  cancel:
//   - In SETUP/ITER/FIX: return to IDLE at next edge; hi/lo keep their pre-operation values; no done.
//   - cancel together with start in IDLE: cancel wins, nothing accepted.
//   - cancel with FIX-exit edge: cancel wins, no write.
//  Intermediate accumulators are internal; hi/lo change only at FIX exit, div-zero exit, or MTHI/MTLO.
// TESTING
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done 35 cycles after start.
//  2. MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3. DIVU a=9 b=0 -> done after 2 cycles; hi=9 lo=0xFFFFFFFF div_zero=1.
//     Next DIVU 9/10 -> lo=0 hi=9 div_zero=0.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000 hi=0; then MTHI a=0x1234 -> hi=0x1234 next edge, busy never set.
//  5. MULT 5*6 with second start asserted mid-ITER -> second ignored; hi=0 lo=30.
//     cancel at ITER cycle 10 -> IDLE next edge, hi/lo unchanged, no done.
//  6. reset_n low at ITER cycle 20 -> immediately hi=lo=0, busy=0, done=0.
//     After release, new MULTU 3*4 -> lo=12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the execute stage and muldiv_unit.
//  start    request, sampled only while the unit is idle
//  op       0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6-7 reserved
//  a, b     rs / rt operands
//  cancel   pipeline flush, aborts an operation in flight
//  hi, lo   architectural HI/LO registers
//  busy     operation in flight
//  done     one-cycle pulse after a mul/div wrote HI/LO
//  div_zero sticky divide-by-zero flag
// master: execute stage side; slave: muldiv_unit side.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, cancel,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit beside the ALU. Executes MULT/MULTU/DIV/DIVU
// into HI/LO with one radix-2 step per cycle, plus single-cycle MTHI/MTLO.
// Ports:
//  clk      rising-edge clock
//  reset_n  asynchronous active-low reset
//  bus      muldiv_unit_if slave: start/op/a/b/cancel in, hi/lo/busy/done/div_zero out
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StIter, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // a_q/b_q hold raw operands until SETUP, magnitudes afterwards.
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    // Datapath helpers.
    always_comb begin
        sign_a  = is_signed_q & a_q[WIDTH-1];
        sign_b  = is_signed_q & b_q[WIDTH-1];
        mag_a   = sign_a ? -a_q : a_q;
        mag_b   = sign_b ? -b_q : b_q;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, b_q};
        // Only used when rem_ge, where the true difference fits in WIDTH bits.
        rem_sub = rem_sh[WIDTH-1:0] - b_q;
        prod    = neg_lo_q ? -acc_q : acc_q;
        quot    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem     = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        dz_d        = dz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d         = bus.a;
                            b_d         = bus.b;
                            is_div_d    = bus.op[1];
                            is_signed_d = bus.op[0];
                            dz_d        = 1'b0;
                            state_d     = StSetup;
                        end
                        3'd4:    hi_d = bus.a;
                        3'd5:    lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            StSetup: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else if (is_div_q && (b_q == '0)) begin
                    hi_d    = a_q;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    a_d      = mag_a;
                    b_d      = mag_b;
                    cnt_d    = '0;
                    neg_lo_d = sign_a ^ sign_b;
                    // Remainder follows the dividend's sign.
                    neg_hi_d = sign_a;
                    acc_d    = {{WIDTH{1'b0}}, (is_div_q ? mag_a : mag_b)};
                    state_d  = StIter;
                end
            end
            StIter: begin
                if (bus.cancel) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        if (rem_ge) begin
                            acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against an
// arithmetic reference model, ignored starts, cancel corners and mid-op reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl,
                                  output logic rdz, output int lat);
        longint      sx, sy, res;
        logic [63:0] w;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        rh  = exp_hi;
        rl  = exp_lo;
        rdz = 1'b0;
        lat = 34;
        case (o)
            3'd0: begin
                w  = {32'd0, x} * {32'd0, y};
                rh = w[63:32];
                rl = w[31:0];
            end
            3'd1: begin
                res = sx * sy;
                w   = res;
                rh  = w[63:32];
                rl  = w[31:0];
            end
            3'd2, 3'd3: begin
                if (y == 32'd0) begin
                    rh  = x;
                    rl  = 32'hFFFF_FFFF;
                    rdz = 1'b1;
                    lat = 1;
                end else if (o == 3'd2) begin
                    rl = x / y;
                    rh = x % y;
                end else begin
                    res = sx / sy;
                    w   = res;
                    rl  = w[31:0];
                    res = sx % sy;
                    w   = res;
                    rh  = w[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Start a mul/div that will be accepted; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        exp_dz    = 1'b0;
    endtask

    // Full mul/div; poke_at >= 0 raises a stray start at that cycle count.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke_at);
        logic [31:0] eh, el;
        logic        edz;
        int          lat;
        int          n;
        model(o, x, y, eh, el, edz, lat);
        issue(o, x, y);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept op=%0d: got %b expected 1", o, bus.busy);
        end
        checks++;
        if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin
            errors++;
            $display("FAIL hilo_hold op=%0d: got %h expected %h", o, {bus.hi, bus.lo},
                     {exp_hi, exp_lo});
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            if (n == poke_at) begin
                bus.start = 1'b1;
                bus.op    = 3'($urandom_range(0, 5));
                bus.a     = $urandom;
            end
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL latency op=%0d a=%h b=%h: got %0d cycles expected %0d", o, x, y, n, lat);
        end
        checks++;
        if ({bus.hi, bus.lo} !== {eh, el}) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                     o, x, y, bus.hi, bus.lo, eh, el);
        end
        checks++;
        if ({bus.div_zero, bus.busy} !== {edz, 1'b0}) begin
            errors++;
            $display("FAIL flags_at_done op=%0d: got dz,busy=%b%b expected %b0", o,
                     bus.div_zero, bus.busy, edz);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse op=%0d: got %b expected 0", o, bus.done);
        end
        exp_hi = eh;
        exp_lo = el;
        exp_dz = edz;
    endtask

    // MTHI/MTLO or reserved op issued from idle.
    task automatic mt_op(input logic [2:0] o, input logic [31:0] x);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        @(negedge clk);
        bus.start = 1'b0;
        if (o == 3'd4) exp_hi = x;
        if (o == 3'd5) exp_lo = x;
        checks++;
        if ({bus.hi, bus.lo, bus.div_zero} !== {exp_hi, exp_lo, exp_dz}) begin
            errors++;
            $display("FAIL move op=%0d: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b", o,
                     bus.hi, bus.lo, bus.div_zero, exp_hi, exp_lo, exp_dz);
        end
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL move_flags op=%0d: got busy,done=%b%b expected 00", o, bus.busy,
                     bus.done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL multu_max: got %h expected FFFFFFFE00000001", {bus.hi, bus.lo});
        end
        run_op(3'd1, 32'hFFFF_FFF9, 32'd3, -1);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg7x3: got %h expected FFFFFFFFFFFFFFEB", {bus.hi, bus.lo});
        end
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, -1);
        checks++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg7by2: got %h expected FFFFFFFFFFFFFFFD", {bus.hi, bus.lo});
        end
        run_op(3'd2, 32'd9, 32'd0, -1);
        checks++;
        if ({bus.hi, bus.lo, bus.div_zero} !== {32'd9, 32'hFFFF_FFFF, 1'b1}) begin
            errors++;
            $display("FAIL divu_by_zero: got hi=%h lo=%h dz=%b expected 9 FFFFFFFF 1", bus.hi,
                     bus.lo, bus.div_zero);
        end
        run_op(3'd2, 32'd9, 32'd10, -1);
        checks++;
        if ({bus.hi, bus.lo, bus.div_zero} !== {32'd9, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL divu_9by10: got hi=%h lo=%h dz=%b expected 9 0 0", bus.hi, bus.lo,
                     bus.div_zero);
        end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        checks++;
        if ({bus.hi, bus.lo} !== 64'h0000_0000_8000_0000) begin
            errors++;
            $display("FAIL div_overflow: got %h expected 0000000080000000", {bus.hi, bus.lo});
        end
        mt_op(3'd4, 32'h0000_1234);
        checks++;
        if (bus.hi !== 32'h0000_1234) begin
            errors++;
            $display("FAIL mthi_1234: got %h expected 00001234", bus.hi);
        end
        mt_op(3'd5, 32'hCAFE_F00D);
        mt_op(3'd6, 32'h1111_1111);
        mt_op(3'd7, 32'h2222_2222);
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if (o >= 3'd4) begin
                mt_op(o, x);
            end else begin
                run_op(o, x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 33) : -1);
            end
        end
    endtask

    task automatic test_ignore_start();
        run_op(3'd1, 32'd5, 32'd6, 15);
        checks++;
        if ({bus.hi, bus.lo} !== 64'd30) begin
            errors++;
            $display("FAIL mult_5x6_ignore: got %h expected 000000000000001E", {bus.hi, bus.lo});
        end
    endtask

    task automatic expect_aborted(input string name);
        int dones;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle: got busy,done=%b%b expected 00", name, bus.busy, bus.done);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL %s_quiet: got %0d active cycles expected 0", name, dones);
        end
        checks++;
        if ({bus.hi, bus.lo, bus.div_zero} !== {exp_hi, exp_lo, exp_dz}) begin
            errors++;
            $display("FAIL %s_state: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b", name,
                     bus.hi, bus.lo, bus.div_zero, exp_hi, exp_lo, exp_dz);
        end
    endtask

    task automatic test_cancel();
        // Cancel at ITER cycle 10.
        issue(3'd0, $urandom, $urandom);
        repeat (11) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        expect_aborted("cancel_iter");
        // Cancel together with start in idle: nothing accepted, sticky flag kept.
        run_op(3'd2, 32'd5, 32'd0, -1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 3'd0;
        @(negedge clk);
        bus.op     = 3'd4;
        bus.a      = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        expect_aborted("cancel_start");
        // Cancel on the FIX exit edge.
        issue(3'd1, $urandom, $urandom);
        repeat (33) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        expect_aborted("cancel_fix");
        // Cancel a divide-by-zero in SETUP: no write, flag was cleared on accept.
        run_op(3'd3, 32'd77, 32'd0, -1);
        issue(3'd2, 32'd88, 32'd0);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        expect_aborted("cancel_setup");
        run_op(3'd2, 32'd100, 32'd7, -1);
    endtask

    task automatic test_reset_mid();
        run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, -1);
        issue(3'd0, $urandom, $urandom);
        repeat (21) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b dz=%b expected all 0",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_hi  = '0;
        exp_lo  = '0;
        exp_dz  = 1'b0;
        run_op(3'd0, 32'd3, 32'd4, -1);
        checks++;
        if ({bus.hi, bus.lo} !== 64'd12) begin
            errors++;
            $display("FAIL multu_3x4_after_reset: got %h expected 000000000000000C",
                     {bus.hi, bus.lo});
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_cancel();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
